// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - shared MIO UART status bit positions and transmitter FSM states
package mio_pkg;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with count; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/mio_uart_tx.sv
// rtl/mio_uart_tx.sv - MIO bus UART transmitter: byte FIFO feeding an 8N1 baud-rate serialiser
module mio_uart_tx
  import mio_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        clr_ovf,
  output logic [31:0] status,
  output logic        txd
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;

  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          baud_wrap;
  logic          overflow;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    baud_wrap = (baud_q == BAUD_LAST);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // txd follows the next state so the start bit appears on the pop edge.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase

    overflow = wr_en && fifo_full && !fifo_pop;
    if (overflow) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status                            = '0;
    status[ST_BUSY]                   = (state_q != IDLE) || !fifo_empty;
    status[ST_FULL]                   = fifo_full;
    status[ST_EMPTY]                  = fifo_empty;
    status[ST_OVF]                    = ovf_q;
    status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_mio_uart_tx.sv
// tb/tb_mio_uart_tx.sv - directed bench for mio_uart_tx with DIV=16 and an 8-entry FIFO
module tb_mio_uart_tx;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        clr_ovf;
  logic [31:0] status;
  logic        txd;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic [6:0] cnt;
  } vec_t;

  vec_t       vecs [3];
  logic [7:0] ob [10];

  mio_uart_tx #(
    .CLK_HZ     (16),
    .BAUD       (1),
    .FIFO_DEPTH (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr_ovf (clr_ovf),
    .status  (status),
    .txd     (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] fr(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Samples 160 cycles of a frame starting at sample k0 (sample 0 is right after the pop edge).
  task automatic check_frame(input logic [9:0] exp, input int k0, input string name);
    for (int k = k0; k < 160; k++) begin
      chk(name, {31'b0, txd}, {31'b0, exp[k / 16]});
      tick();
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'h00, frame: 10'h200, cnt: 7'd2};
    vecs[1] = '{data: 8'hFF, frame: 10'h3FE, cnt: 7'd1};
    vecs[2] = '{data: 8'hA5, frame: 10'h34A, cnt: 7'd0};
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

    n_checks = 0;
    n_errors = 0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    clr_ovf  = 1'b0;
    rst      = 1'b0;
    #1 rst   = 1'b1;
    #1;
    chk("reset_txd", {31'b0, txd}, 32'h1);
    chk("reset_status", status, 32'h4);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_txd", {31'b0, txd}, 32'h1);
      chk("idle_status", status, 32'h4);
    end

    // Single byte 0x55 with exact edge timing.
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    chk("t2_push_status", status, 32'h11);
    chk("t2_push_txd", {31'b0, txd}, 32'h1);
    tick();
    chk("t2_pop_status", status, 32'h5);
    check_frame(10'h2AA, 0, "t2_frame_55");
    chk("t2_done_status", status, 32'h4);
    chk("t2_done_txd", {31'b0, txd}, 32'h1);
    repeat (5) tick();

    // Three back-to-back writes from the vector table.
    wr_en   = 1'b1;
    wr_data = vecs[0].data;
    tick();
    wr_data = vecs[1].data;
    tick();
    chk("t3_first_start", {31'b0, txd}, 32'h0);
    wr_data = vecs[2].data;
    tick();
    wr_en = 1'b0;
    for (int v = 0; v < 3; v++) begin
      if (v > 0) begin
        chk("t3_gap", {31'b0, txd}, 32'h1);
        tick();
      end
      chk("t3_count", {25'b0, status[10:4]}, {25'b0, vecs[v].cnt});
      check_frame(vecs[v].frame, (v == 0) ? 1 : 0, "t3_frame");
    end
    chk("t3_done_status", status, 32'h4);
    repeat (3) tick();

    // Ten writes while the first is in flight: one popped, eight queued, one dropped.
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'b1;
      wr_data = ob[i];
      tick();
      if (i == 8) chk("t4_full_status", status, 32'h83);
    end
    chk("t4_ovf_status", status, 32'h8B);
    wr_data = 8'hEE;
    clr_ovf = 1'b1;
    tick();
    chk("t4_set_wins", status, 32'h8B);
    wr_en = 1'b0;
    tick();
    clr_ovf = 1'b0;
    chk("t4_cleared", status, 32'h83);
    repeat (150) tick();

    // Full FIFO, push on the exact pop cycle.
    chk("t5_pre_txd", {31'b0, txd}, 32'h1);
    chk("t5_pre_status", status, 32'h83);
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    chk("t5_pop_push_status", status, 32'h83);
    check_frame(fr(ob[1]), 0, "t5_frame");
    for (int i = 2; i < 10; i++) begin
      chk("t5_gap", {31'b0, txd}, 32'h1);
      tick();
      check_frame(fr((i == 9) ? 8'h3C : ob[i]), 0, "t5_frame");
    end
    chk("t5_done_status", status, 32'h4);
    repeat (3) tick();

    // Asynchronous reset in the middle of data bit 3 of 0xC3 with a second byte queued.
    wr_en   = 1'b1;
    wr_data = 8'hC3;
    tick();
    wr_data = 8'h81;
    tick();
    wr_en = 1'b0;
    repeat (69) tick();
    chk("t6_bit3", {31'b0, txd}, 32'h0);
    chk("t6_pre_status", status, 32'h11);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_txd", {31'b0, txd}, 32'h1);
    chk("t6_async_status", status, 32'h4);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("t6_quiet_txd", {31'b0, txd}, 32'h1);
      chk("t6_quiet_status", status, 32'h4);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
